// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel, then summed LSB-first
// through a single full-adder cell with the carry held in a flip-flop between slices.

module one_bit_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic co
);
   assign sum = a ^ b ^ ci;
   assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             co_q, co_d;

   logic             cell_sum;
   logic             cell_co;

   one_bit_adder u_cell (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .ci  (cy_q),
      .sum (cell_sum),
      .co  (cell_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         co_q    <= co_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      co_d    = co_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               cy_d    = ci;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_sh_d = {cell_sum, s_sh_q[WIDTH-1:1]};
            cy_d   = cell_co;
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            // Final slice: publish the completed shift value, not the stale register.
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {cell_sum, s_sh_q[WIDTH-1:1]};
               co_d    = cell_co;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == RUN) || (state_q == DONE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an acceptance model queues a+b+ci per accepted start,
// and a negedge monitor pops and checks value, completion edge, pulse width and output hold.

module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         ci;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         co;

   typedef struct {
      logic [W:0] val;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   int   edge_n;
   int   next_free;
   int   n_checks = 0;
   int   n_fail   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Acceptance model: a start seen at an edge is taken once WIDTH+2 edges have passed
   // since the previous acceptance; the result is due WIDTH edges later.
   initial begin
      exp_t e;
      edge_n    = 0;
      next_free = 0;
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            exp_q.delete();
            next_free = edge_n + 1;
         end else if (start && edge_n >= next_free) begin
            e.val = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            e.due = edge_n + W;
            exp_q.push_back(e);
            next_free = edge_n + W + 2;
         end
      end
   end

   // Monitor
   initial begin
      exp_t       e;
      logic       prev_done;
      logic [W:0] last_res;
      prev_done = 1'b0;
      last_res  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_done = 1'b0;
            last_res  = {co, sum};
            continue;
         end
         if (prev_done)
            chk(!busy && !done, "idle_after_done", {30'd0, busy, done}, 32'd0);
         if (done) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "spurious_done", {23'd0, co, sum}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk({co, sum} == e.val, "result", {23'd0, co, sum}, {23'd0, e.val});
               chk(edge_n == e.due, "latency", edge_n, e.due);
            end
         end else begin
            chk({co, sum} == last_res, "hold", {23'd0, co, sum}, {23'd0, last_res});
            if (exp_q.size() > 0 && exp_q[0].due < edge_n) begin
               e = exp_q.pop_front();
               chk(1'b0, "missed_done", edge_n, e.due);
            end
         end
         last_res  = {co, sum};
         prev_done = done;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk(1'b0, "idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      a     = av;
      b     = bv;
      ci    = cv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      ci    = 1'($urandom);
   endtask

   task automatic wait_done(input logic [W:0] exp, input string nm);
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk(1'b0, "done_timeout", 32'd0, 32'd1);
      else       chk({co, sum} == exp, nm, {23'd0, co, sum}, {23'd0, exp});
   endtask

   initial begin
      int n_done;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      ci    = 1'b0;
      #12;
      chk(!busy, "rst_busy", {31'd0, busy}, 32'd0);
      chk(!done, "rst_done", {31'd0, done}, 32'd0);
      chk(sum == '0, "rst_sum", {24'd0, sum}, 32'd0);
      chk(!co, "rst_co", {31'd0, co}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // Directed operands
      wait_idle(); issue(8'h00, 8'h00, 1'b0); wait_done(9'h000, "zero");
      wait_idle(); issue(8'hFF, 8'h01, 1'b0); wait_done(9'h100, "ripple");
      wait_idle(); issue(8'hA5, 8'h5A, 1'b1); wait_done(9'h100, "a5_5a");
      wait_idle(); issue(8'h3C, 8'h0F, 1'b0);
      repeat (3) @(negedge clk);
      chk({co, sum} == 9'h100, "prev_held", {23'd0, co, sum}, 32'h100);
      wait_done(9'h04B, "3c_0f");

      // Start held high: operands wiggle while busy and must not leak in
      wait_idle();
      @(negedge clk);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) begin
            a = W'($urandom);
            b = W'($urandom);
         end else begin
            a = 8'h10;
            b = 8'h20;
         end
         ci    = 1'b0;
         start = 1'b1;
         if (done) begin
            n_done++;
            chk({co, sum} == 9'h030, "held_start_sum", {23'd0, co, sum}, 32'h30);
         end
      end
      start = 1'b0;
      chk(n_done == 4, "held_start_count", n_done, 32'd4);

      // Reset in the middle of a run
      wait_idle(); issue(8'hFF, 8'h01, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk(!busy, "midrst_busy", {31'd0, busy}, 32'd0);
      chk(!done, "midrst_done", {31'd0, done}, 32'd0);
      chk(sum == '0, "midrst_sum", {24'd0, sum}, 32'd0);
      chk(!co, "midrst_co", {31'd0, co}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (15) @(negedge clk);
      wait_idle(); issue(8'h01, 8'h02, 1'b0); wait_done(9'h003, "after_rst");

      // Random traffic, including back-to-back issue
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         wait_idle();
         issue(W'($urandom), W'($urandom), 1'($urandom));
      end

      for (int n = 0; n < 50 && exp_q.size() > 0; n++) @(negedge clk);
      @(negedge clk);
      chk(exp_q.size() == 0, "drain", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
